// File: rtl/radiant_event_hdr_reader.sv
// radiant_event_hdr_reader
//   Wishbone master that drains one event header from the event control
//   core's header window. When a DMA request is pending it reads
//   NUM_DWORDS dwords starting at BASE_ADDR, forwards each one on a
//   valid/ready stream, then pulses event_readout_ready_o to pop the
//   request. Bus timeouts and bus errors set sticky error flags.
//
//   Optional feature macro: RADIANT_HDR_ID_CHECK_EN
//     defined   -> dword 0 is compared to 32'h52444530 ("RDE0"); a
//                  mismatch sets err_o[1] but the header still streams.
//     undefined -> no compare logic, err_o[1] stays 0.
//
// Ports
//   clk_i, rst_n_i          clock, asynchronous active-low reset
//   enable_i                allow new headers to start
//   clr_err_i               synchronous clear of err_o
//   event_ready_i           request FIFO valid (first-word-fall-through)
//   event_ready_type_i      request type, latched when a header starts
//   event_readout_ready_o   one-cycle pop pulse after the last dword
//   wbm_*                   wishbone master (read only)
//   hdr_t*                  header dword stream
//   busy_o                  header in flight
//   err_o                   [0] timeout/bus error, [1] identifier mismatch
//   hdr_count_o             completed headers (wraps)
module radiant_event_hdr_reader #(
   parameter logic [8:0]  BASE_ADDR      = 9'h100,
   parameter int unsigned NUM_DWORDS     = 8,
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned HOLDOFF_CYCLES = 2
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        enable_i,
   input  logic        clr_err_i,
   input  logic        event_ready_i,
   input  logic        event_ready_type_i,
   output logic        event_readout_ready_o,
   output logic        wbm_cyc_o,
   output logic        wbm_stb_o,
   output logic        wbm_we_o,
   output logic [8:0]  wbm_adr_o,
   input  logic [31:0] wbm_dat_i,
   input  logic        wbm_ack_i,
   input  logic        wbm_err_i,
   output logic [31:0] hdr_tdata_o,
   output logic        hdr_tvalid_o,
   input  logic        hdr_tready_i,
   output logic        hdr_tlast_o,
   output logic        hdr_tuser_o,
   output logic        busy_o,
   output logic [1:0]  err_o,
   output logic [15:0] hdr_count_o
);

   localparam logic [2:0] LAST_IDX  = 3'(NUM_DWORDS - 1);
   localparam logic [7:0] TMO_LAST  = 8'(TIMEOUT_CYCLES - 1);
   localparam logic [7:0] HOLD_LAST = 8'(HOLDOFF_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_REQ, S_PUSH, S_POP, S_HOLD, S_ABORT
   } state_t;

   state_t      state_q, state_d;
   logic [2:0]  idx_q, idx_d;
   logic [7:0]  tmo_q, tmo_d;
   logic [7:0]  hold_q, hold_d;
   logic [31:0] dat_q, dat_d;
   logic        type_q, type_d;
   logic [1:0]  err_q, err_d;
   logic        blk_q, blk_d;     // set by a timeout, holds off new headers
   logic [15:0] cnt_q, cnt_d;

   logic term;
   logic id_bad;

   assign term = wbm_ack_i | wbm_err_i;

`ifdef RADIANT_HDR_ID_CHECK_EN
   localparam logic [31:0] HDR_ID = 32'h52444530;
   assign id_bad = (idx_q == 3'd0) && (wbm_dat_i != HDR_ID);
`else
   assign id_bad = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      tmo_d   = tmo_q;
      hold_d  = hold_q;
      dat_d   = dat_q;
      type_d  = type_q;
      cnt_d   = cnt_q;
      blk_d   = blk_q;
      // clear first so that any error raised below in the same cycle wins
      err_d   = clr_err_i ? 2'b00 : err_q;
      if (clr_err_i && err_q[0]) blk_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (enable_i && event_ready_i && !blk_q) begin
               type_d  = event_ready_type_i;
               idx_d   = 3'd0;
               tmo_d   = 8'd0;
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            if (term) begin
               dat_d = wbm_dat_i;
               if (wbm_err_i) err_d[0] = 1'b1;
               if (id_bad)    err_d[1] = 1'b1;
               state_d = S_PUSH;
            end else if (tmo_q == TMO_LAST) begin
               err_d[0] = 1'b1;
               blk_d    = 1'b1;
               state_d  = S_ABORT;
            end else begin
               tmo_d = tmo_q + 8'd1;
            end
         end
         S_PUSH: begin
            // the next bus cycle starts only after this dword is accepted
            if (hdr_tready_i) begin
               if (idx_q == LAST_IDX) begin
                  state_d = S_POP;
               end else begin
                  idx_d   = idx_q + 3'd1;
                  tmo_d   = 8'd0;
                  state_d = S_REQ;
               end
            end
         end
         S_POP: begin
            cnt_d   = cnt_q + 16'd1;
            idx_d   = 3'd0;
            hold_d  = 8'd0;
            state_d = S_HOLD;
         end
         S_HOLD: begin
            // give the FWFT request FIFO time to present its next valid
            if (hold_q == HOLD_LAST) state_d = S_IDLE;
            else                     hold_d  = hold_q + 8'd1;
         end
         S_ABORT: begin
            idx_d   = 3'd0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= S_IDLE;
         idx_q   <= 3'd0;
         tmo_q   <= 8'd0;
         hold_q  <= 8'd0;
         dat_q   <= 32'd0;
         type_q  <= 1'b0;
         err_q   <= 2'b00;
         blk_q   <= 1'b0;
         cnt_q   <= 16'd0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         tmo_q   <= tmo_d;
         hold_q  <= hold_d;
         dat_q   <= dat_d;
         type_q  <= type_d;
         err_q   <= err_d;
         blk_q   <= blk_d;
         cnt_q   <= cnt_d;
      end
   end

   // Strobes decode straight from the state register, so an asynchronous
   // reset drops the bus cycle and the stream valid immediately.
   assign wbm_cyc_o             = (state_q == S_REQ);
   assign wbm_stb_o             = (state_q == S_REQ);
   assign wbm_we_o              = 1'b0;
   assign wbm_adr_o             = BASE_ADDR + {4'b0000, idx_q, 2'b00};
   assign hdr_tdata_o           = dat_q;
   assign hdr_tvalid_o          = (state_q == S_PUSH);
   assign hdr_tlast_o           = (state_q == S_PUSH) && (idx_q == LAST_IDX);
   assign hdr_tuser_o           = type_q;
   assign event_readout_ready_o = (state_q == S_POP);
   assign busy_o                = (state_q != S_IDLE) && (state_q != S_HOLD);
   assign err_o                 = err_q;
   assign hdr_count_o           = cnt_q;

endmodule

// File: tb/tb_radiant_event_hdr_reader.sv
module tb_radiant_event_hdr_reader;

   localparam logic [31:0] ID = 32'h52444530;
`ifdef RADIANT_HDR_ID_CHECK_EN
   localparam bit IDCHK = 1'b1;
`else
   localparam bit IDCHK = 1'b0;
`endif

   logic        clk = 1'b0, rst_n = 1'b0;
   logic        enable = 1'b0, clr_err = 1'b0, ev_ready = 1'b0, ev_type = 1'b0;
   logic        pop, cyc, stb, we;
   logic [8:0]  adr;
   logic [31:0] wdat = '0;
   logic        ack = 1'b0, werr = 1'b0;
   logic [31:0] tdata;
   logic        tvalid, tready = 1'b0, tlast, tuser, busy;
   logic [1:0]  err;
   logic [15:0] cnt;

   always #5 clk = ~clk;

   radiant_event_hdr_reader dut (
      .clk_i(clk), .rst_n_i(rst_n), .enable_i(enable), .clr_err_i(clr_err),
      .event_ready_i(ev_ready), .event_ready_type_i(ev_type),
      .event_readout_ready_o(pop), .wbm_cyc_o(cyc), .wbm_stb_o(stb),
      .wbm_we_o(we), .wbm_adr_o(adr), .wbm_dat_i(wdat), .wbm_ack_i(ack),
      .wbm_err_i(werr), .hdr_tdata_o(tdata), .hdr_tvalid_o(tvalid),
      .hdr_tready_i(tready), .hdr_tlast_o(tlast), .hdr_tuser_o(tuser),
      .busy_o(busy), .err_o(err), .hdr_count_o(cnt)
   );

   int n_cmp = 0, n_bad = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Source headers: header k, dword n. Dword 0 carries the identifier.
   logic [31:0] dmem [64][8];
   bit          type_tbl [64];

   // Test-mode knobs (written by the sequence, read by the environment)
   int never_idx = -1, err_idx = -1, ack_lat = 1, tready_pct = 100;
   int stall_idx = -1, stall_len = 5, resync_cnt = 0;
   bit bad_id = 1'b0;

   function automatic logic [31:0] exp_word(input int k, input int n);
      if (n < 0 || n > 7) return 32'h0;
      if (n == 0) return bad_id ? 32'hDEADBEEF : ID;
      return dmem[k % 64][n];
   endfunction

   // Environment / reference-model state
   int seen_resync = 0, w = 0, beat = 0, cur_hdr = 0, stall_cnt = 0, stalls = 0;
   int cyc_run = 0, last_run = 0, gap = 0, ai = 0;
   bit gap_arm = 1'b0, prev_stall = 1'b0, prev_pop = 1'b0;
   logic [31:0] prev_data = '0;

   typedef struct {
      int         nhdr;
      int         lat;
      int         rdy_pct;
      int         err_idx;
      bit         bad_id;
      int         stall_idx;
      logic [1:0] exp_err;
   } vec_t;
   vec_t vt [7];

   int np, ne, c0, s0, seen;
   bit to;

   // Request FIFO model: event_ready stays high until nhdr pops were seen.
   task automatic run_hdrs(input int nhdr, output int npop, output int nerr0, output bit tmo);
      int left;
      left = nhdr; npop = 0; nerr0 = 0; tmo = 1'b0;
      enable = 1'b1; ev_ready = 1'b1;
      for (int i = 0; i < 600 * nhdr + 400 && left > 0; i++) begin
         @(negedge clk);
         if (err[0]) nerr0++;
         if (pop) begin npop++; left--; ev_ready = (left > 0); end
      end
      if (left > 0) tmo = 1'b1;
      ev_ready = 1'b0;
      repeat (6) @(negedge clk);
   endtask

   initial begin
      for (int k = 0; k < 64; k++) begin
         type_tbl[k] = 1'($urandom_range(1));
         for (int n = 0; n < 8; n++) dmem[k][n] = $urandom;
      end

      // Environment: wishbone slave, stream sink and scoreboard.
      fork
         forever begin
            @(negedge clk);
            if (resync_cnt != seen_resync) begin
               seen_resync = resync_cnt;
               beat = 0; cur_hdr++; stall_cnt = 0; w = 0; gap_arm = 1'b0; prev_stall = 1'b0;
            end
            if (cyc) begin
               check("wb_adr", 32'(adr), 32'(9'h100 + 9'(4 * beat)));
               check("wb_stb", 32'(stb), 32'd1);
               check("wb_we", 32'(we), 32'd0);
               ai = (int'(adr) - 256) / 4;
               if (ai == never_idx) begin
                  ack = 1'b0; werr = 1'b0;
               end else if (w + 1 >= ack_lat) begin
                  if (ai == err_idx) begin werr = 1'b1; ack = 1'b0; end
                  else begin ack = 1'b1; werr = 1'b0; end
                  wdat = exp_word(cur_hdr, ai);
                  w++;
               end else begin
                  ack = 1'b0; werr = 1'b0; w++;
               end
            end else begin
               ack = 1'b0; werr = 1'b0; w = 0; wdat = $urandom;
            end
            if (cyc) cyc_run++;
            else if (cyc_run != 0) begin last_run = cyc_run; cyc_run = 0; end

            if (tvalid) check("no_bus_in_push", 32'(cyc), 32'd0);
            if (prev_stall) begin
               check("hold_valid", 32'(tvalid), 32'd1);
               check("hold_data", tdata, prev_data);
            end
            if (tvalid && beat == stall_idx && stall_cnt < stall_len) begin
               tready = 1'b0; stall_cnt++;
            end else begin
               tready = ($urandom_range(99) < tready_pct);
            end
            if (tvalid && !tready) stalls++;
            prev_stall = tvalid && !tready;
            prev_data  = tdata;
            if (tvalid && tready) begin
               check("tdata", tdata, exp_word(cur_hdr, beat));
               check("tlast", 32'(tlast), 32'(beat == 7));
               check("tuser", 32'(tuser), 32'(type_tbl[cur_hdr % 64]));
               beat++;
            end
            if (pop) begin
               check("pop_after_last", 32'(beat), 32'd8);
               check("pop_width", 32'(prev_pop), 32'd0);
               beat = 0; cur_hdr++; stall_cnt = 0; gap = 0; gap_arm = 1'b1;
            end else if (gap_arm) begin
               if (cyc) begin
                  check("holdoff_gap", 32'(gap >= 2), 32'd1);
                  gap_arm = 1'b0;
               end else gap++;
            end
            prev_pop = pop;
            // type only matters while idle; scramble it during a header
            ev_type = busy ? 1'($urandom) : type_tbl[cur_hdr % 64];
         end
      join_none

      // Reset state
      #1;
      check("rst_cyc", 32'(cyc), 0);     check("rst_stb", 32'(stb), 0);
      check("rst_adr", 32'(adr), 32'h100); check("rst_tvalid", 32'(tvalid), 0);
      check("rst_tlast", 32'(tlast), 0); check("rst_tdata", tdata, 0);
      check("rst_pop", 32'(pop), 0);     check("rst_busy", 32'(busy), 0);
      check("rst_err", 32'(err), 0);     check("rst_cnt", 32'(cnt), 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Table-driven header runs
      vt[0] = '{1, 1, 100, -1, 1'b0, -1, 2'b00};
      vt[1] = '{3, 1, 100, -1, 1'b0, -1, 2'b00};
      vt[2] = '{1, 1, 100, -1, 1'b0,  3, 2'b00};
      vt[3] = '{2, 3,  60,  5, 1'b0, -1, 2'b01};
      vt[4] = '{1, 1, 100, -1, 1'b1, -1, {IDCHK, 1'b0}};
      vt[5] = '{2, 2,  50, -1, 1'b0, -1, 2'b00};
      vt[6] = '{2, 4,  30,  0, 1'b0,  6, 2'b01};
      for (int v = 0; v < 12; v++) begin
         vec_t cur;
         if (v < 7) cur = vt[v];
         else cur = '{$urandom_range(1, 3), $urandom_range(1, 4), $urandom_range(20, 100),
                      -1, 1'b0, -1, 2'b00};
         ack_lat = cur.lat; tready_pct = cur.rdy_pct; err_idx = cur.err_idx;
         bad_id = cur.bad_id; stall_idx = cur.stall_idx;
         clr_err = 1'b1; @(negedge clk); clr_err = 1'b0;
         c0 = int'(cnt); s0 = stalls;
         run_hdrs(cur.nhdr, np, ne, to);
         check($sformatf("vec%0d_done", v), 32'(to), 0);
         check($sformatf("vec%0d_pops", v), 32'(np), 32'(cur.nhdr));
         check($sformatf("vec%0d_count", v), 32'(16'(int'(cnt) - c0)), 32'(cur.nhdr));
         check($sformatf("vec%0d_err", v), 32'(err), 32'(cur.exp_err));
         check($sformatf("vec%0d_idle", v), 32'(busy), 0);
         if (cur.stall_idx >= 0 && cur.rdy_pct == 100)
            check($sformatf("vec%0d_stall", v), 32'(stalls - s0), 5);
      end
      err_idx = -1; bad_id = 1'b0; stall_idx = -1; ack_lat = 1; tready_pct = 100;
      clr_err = 1'b1; @(negedge clk); clr_err = 1'b0;

      // Missing ack on dword 2 -> abort, blocked until clr_err
      never_idx = 2; c0 = int'(cnt); np = 0;
      enable = 1'b1; ev_ready = 1'b1;
      for (int i = 0; i < 700 && !err[0]; i++) begin
         @(negedge clk);
         if (pop) np++;
      end
      check("abort_err_seen", 32'(err), 32'h1);
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (cyc || busy || pop) seen++;
      end
      check("abort_len", 32'(last_run), 255);
      check("abort_no_pop", 32'(np), 0);
      check("abort_blocked", 32'(seen), 0);
      check("abort_err_sticky", 32'(err), 32'h1);
      check("abort_count", 32'(cnt), 32'(c0));
      never_idx = -1; resync_cnt++;
      @(negedge clk); clr_err = 1'b1; @(negedge clk); clr_err = 1'b0;
      run_hdrs(1, np, ne, to);
      check("abort_restart_pop", 32'(np), 1);
      check("abort_restart_err", 32'(err), 0);
      check("abort_restart_cnt", 32'(cnt), 32'(16'(c0 + 1)));

      // enable gates starts; dropping enable/ready mid-header still finishes
      c0 = int'(cnt); seen = 0; enable = 1'b0; ev_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin @(negedge clk); if (busy) seen++; end
      check("enable_gate", 32'(seen), 0);
      enable = 1'b1;
      for (int i = 0; i < 10 && !busy; i++) @(negedge clk);
      ev_ready = 1'b0; enable = 1'b0; np = 0;
      for (int i = 0; i < 300 && np == 0; i++) begin @(negedge clk); if (pop) np++; end
      seen = 0;
      for (int i = 0; i < 10; i++) begin @(negedge clk); if (busy) seen++; end
      check("drop_ready_pop", 32'(np), 1);
      check("drop_ready_idle", 32'(seen), 0);
      check("drop_ready_cnt", 32'(cnt), 32'(16'(c0 + 1)));

      // clr_err held while a bus error arrives: the set wins for one cycle
      err_idx = 0; clr_err = 1'b1;
      run_hdrs(1, np, ne, to);
      clr_err = 1'b0; err_idx = -1;
      check("set_wins_pulse", 32'(ne), 1);
      check("set_wins_pop", 32'(np), 1);

      // Asynchronous reset during the request of dword 4
      enable = 1'b1; ev_ready = 1'b1;
      for (int i = 0; i < 400 && !(cyc && adr == 9'h110); i++) @(negedge clk);
      check("rst_at_dw4", 32'(cyc && adr == 9'h110), 1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_cyc", 32'(cyc), 0);   check("arst_stb", 32'(stb), 0);
      check("arst_tvalid", 32'(tvalid), 0); check("arst_pop", 32'(pop), 0);
      check("arst_cnt", 32'(cnt), 0);
      resync_cnt++; ev_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 10; i++) begin @(negedge clk); if (busy || cyc) seen++; end
      check("post_rst_idle", 32'(seen), 0);
      check("post_rst_adr", 32'(adr), 32'h100);
      run_hdrs(1, np, ne, to);
      check("post_rst_pop", 32'(np), 1);
      check("post_rst_cnt", 32'(cnt), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
